system_top: RTL and testbench
=============================

// Module: system_top
// PURPOSE
//  FPGA system shell: bring-up sequencer plus UART console for the SoC.
//  Holds the core in reset until the reset hold count expires, DDR calibration completes and the host signals done.
//  Then runs an 8N1 UART echo with RTS/CTS flow control.
// PARAMETERS
//  RST_HOLD_CYCLES  default 500  cycles core_rst held after sys_rst deasserts
//  CLKS_PER_BIT     default 868  sys_clk cycles per UART bit (>=4)
// PORTS
//  sys_clk              in   1  single system clock; all logic on rising edge
//  sys_rst              in   1  asynchronous, active-high reset
//  init_calib_complete  in   1  DDR calibration done (async level)
//  host_done            in   1  host bring-up done (async level)
//  uart_rx              in   1  serial in, idle high
//  uart_ctsn            in   1  clear-to-send, active low (async)
//  uart_tx              out  1  serial out, idle high
//  uart_rtsn            out  1  request-to-send, active low
//  core_rst             out  1  core reset, active high
//  host_done_reg        out  1  sticky host_done, post-sync
//  calib_done_reg       out  1  synchronised init_calib_complete
//  uart_overrun         out  1  sticky: rx byte dropped
// BEHAVIOUR
//  Reset values:
//   - uart_tx=1, uart_rtsn=1, core_rst=1
//   - host_done_reg=0, calib_done_reg=0, uart_overrun=0
//   - FSM=HOLD, counters=0, buffer empty
//  Inputs: init_calib_complete, host_done, uart_rx and uart_ctsn each pass a 2-flop synchroniser (2-cycle latency).
//  FSM states:
//   - HOLD: count to RST_HOLD_CYCLES-1, then go to CALIB.
//   - CALIB: go to HOST when calib_done_reg=1.
//   - HOST: go to RUN when host_done_reg=1.
//   - RUN: terminal until reset.
//  host_done_reg is set by synced host_done and cleared only by sys_rst. It may be set in any state; HOST passes through in 1 cycle if already set.
//  core_rst=0 only in RUN; it deasserts on the cycle after entry to RUN.
//  If calibration drops after RUN: ignored; the FSM stays in RUN.
//  UART RX: active only in RUN.
//   - Falling edge starts a byte; sample mid-bit (CLKS_PER_BIT/2) to confirm the start bit.
//   - If the start bit is high at mid-bit, treat it as a glitch and return to idle.
//   - 8 data bits are taken LSB first, then one stop bit.
//   - Stop bit=0: byte discarded (framing error), no flag.
//  Echo buffer: 1 byte deep.
//   - A valid rx byte is written at the stop-bit sample if the buffer is empty.
//   - Otherwise the byte is dropped and uart_overrun is set (sticky).
//  uart_rtsn=0 iff in RUN and buffer empty, else 1.
//  UART TX:
//   - Starts when the buffer is full, synced ctsn=0 and TX is idle.
//   - The buffer empties on the start-bit cycle.
//   - 10-bit frame: start, 8 data LSB first, stop; each bit CLKS_PER_BIT cycles.
//   - ctsn rising mid-frame does not abort the frame; it only blocks the next start.
//  Simultaneous rx write and tx load on the same cycle: the load empties the buffer first, so the write succeeds.
//  sys_rst mid-operation returns everything to reset values immediately; an in-flight frame is truncated and uart_tx=1.
// CONFIGURATION
//  BOOT_BANNER_EN defined:
//   - On entry to RUN, TX sends "OK\r\n" (0x4F,0x4B,0x0D,0x0A) once, obeying ctsn.
//   - uart_rtsn is held 1 and RX is disabled until the last banner stop bit completes; echo runs afterwards.
//  BOOT_BANNER_EN undefined: no banner logic; echo is active immediately in RUN.
// TESTING
//  1. Reset and sequencing: sys_rst=1 then 0; calib=1 at cycle 100; host_done=1 at 600 -> core_rst=0 at ~603; all outputs at reset values before that.
//  2. Early host_done: host_done=1 during HOLD, calib=1 late -> host_done_reg=1 in HOLD; RUN 1 cycle after the HOST state.
//  3. Echo: CLKS_PER_BIT=8, ctsn=0, rx 0xA5 -> uart_tx replays 0xA5 frame; rtsn 1 while buffered.
//  4. Flow control: ctsn=1, rx 0x3C then 0x55 -> no tx, overrun=1, 0x3C retained; ctsn=0 -> tx 0x3C only.
//  5. Framing: rx 0x12 with stop bit 0 -> no echo, overrun stays 0.
//  6. Reset mid-tx: assert sys_rst mid-frame -> uart_tx=1, core_rst=1 same cycle.

Source files
------------

// File: rtl/system_top.sv
// system_top: FPGA shell with a bring-up reset sequencer and an 8N1 UART echo
// console with RTS/CTS flow control and a one-byte echo buffer.
// Optional feature: define BOOT_BANNER_EN to send "OK\r\n" once on entry to RUN
// before the echo console is enabled.
module system_top #(
   parameter int unsigned RST_HOLD_CYCLES = 500,
   parameter int unsigned CLKS_PER_BIT    = 868
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic init_calib_complete,
   input  logic host_done,
   input  logic uart_rx,
   input  logic uart_ctsn,
   output logic uart_tx,
   output logic uart_rtsn,
   output logic core_rst,
   output logic host_done_reg,
   output logic calib_done_reg,
   output logic uart_overrun
);

   localparam int unsigned HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam int unsigned BW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {ST_HOLD, ST_CALIB, ST_HOST, ST_RUN} seq_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   seq_state_t    state;
   rx_state_t     rx_state;
   logic [HW-1:0] hold_cnt;
   logic          calib_meta, host_meta, rx_meta, rx_s, rx_prev, cts_meta, cts_s;
   logic          run, rx_en, rx_valid;
   logic [BW-1:0] rx_cnt, tx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift, buf_data, tx_byte;
   logic          buf_full, tx_busy, tx_load_echo, tx_start;
   logic [3:0]    tx_bit;
   logic [8:0]    tx_shift;

   // Two-flop synchronisers for all asynchronous inputs; host_done is made sticky.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         calib_meta     <= 1'b0;
         calib_done_reg <= 1'b0;
         host_meta      <= 1'b0;
         host_done_reg  <= 1'b0;
         rx_meta        <= 1'b1;
         rx_s           <= 1'b1;
         rx_prev        <= 1'b1;
         cts_meta       <= 1'b1;
         cts_s          <= 1'b1;
      end else begin
         calib_meta     <= init_calib_complete;
         calib_done_reg <= calib_meta;
         host_meta      <= host_done;
         host_done_reg  <= host_done_reg | host_meta;
         rx_meta        <= uart_rx;
         rx_s           <= rx_meta;
         rx_prev        <= rx_s;
         cts_meta       <= uart_ctsn;
         cts_s          <= cts_meta;
      end
   end

   // Bring-up sequencer; core_rst releases the cycle after RUN is entered.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= ST_HOLD;
         hold_cnt <= '0;
         core_rst <= 1'b1;
      end else begin
         core_rst <= (state != ST_RUN);
         unique case (state)
            ST_HOLD:  if (hold_cnt == HOLD_LAST) state <= ST_CALIB;
                      else hold_cnt <= hold_cnt + 1'b1;
            ST_CALIB: if (calib_done_reg) state <= ST_HOST;
            ST_HOST:  if (host_done_reg) state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

   assign run          = (state == ST_RUN);
   assign tx_load_echo = rx_en && buf_full && !cts_s && !tx_busy;
   assign rx_valid     = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s;
   assign uart_rtsn    = !(rx_en && !buf_full);

`ifdef BOOT_BANNER_EN
   logic [2:0] ban_idx;
   logic       ban_done, ban_load;
   logic [7:0] ban_byte;

   assign ban_load = run && !ban_done && (ban_idx != 3'd4) && !tx_busy && !cts_s;
   assign rx_en    = run && ban_done;
   assign tx_start = ban_load || tx_load_echo;
   assign tx_byte  = ban_load ? ban_byte : buf_data;

   // Banner character lookup.
   always_comb begin
      ban_byte = 8'h0A;
      case (ban_idx)
         3'd0:    ban_byte = 8'h4F;
         3'd1:    ban_byte = 8'h4B;
         3'd2:    ban_byte = 8'h0D;
         default: ban_byte = 8'h0A;
      endcase
   end

   // Banner progress; done once the last banner frame has left the transmitter.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ban_idx  <= '0;
         ban_done <= 1'b0;
      end else begin
         if (ban_load) ban_idx <= ban_idx + 1'b1;
         if (ban_idx == 3'd4 && !tx_busy) ban_done <= 1'b1;
      end
   end
`else
   assign rx_en    = run;
   assign tx_start = tx_load_echo;
   assign tx_byte  = buf_data;
`endif

   // UART receiver: falling edge, mid-bit start confirm, 8 data bits LSB first, stop.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else if (!rx_en) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
      end else begin
         unique case (rx_state)
            RX_IDLE: if (rx_prev && !rx_s) begin
               rx_state <= RX_START;
               rx_cnt   <= '0;
            end
            RX_START: if (rx_cnt == HALF_LAST) begin
               rx_cnt   <= '0;
               rx_bit   <= '0;
               rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_DATA: if (rx_cnt == BIT_LAST) begin
               rx_cnt   <= '0;
               rx_shift <= {rx_s, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state <= RX_STOP;
               else rx_bit <= rx_bit + 1'b1;
            end else rx_cnt <= rx_cnt + 1'b1;
            default: if (rx_cnt == BIT_LAST) begin
               rx_cnt   <= '0;
               rx_state <= RX_IDLE;
            end else rx_cnt <= rx_cnt + 1'b1;
         endcase
      end
   end

   // One-byte echo buffer; a same-cycle transmit load frees the slot for the write.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         buf_full     <= 1'b0;
         buf_data     <= '0;
         uart_overrun <= 1'b0;
      end else begin
         if (rx_valid && (!buf_full || tx_load_echo)) begin
            buf_full <= 1'b1;
            buf_data <= rx_shift;
         end else if (tx_load_echo) begin
            buf_full <= 1'b0;
         end
         if (rx_valid && buf_full && !tx_load_echo) uart_overrun <= 1'b1;
      end
   end

   // UART transmitter: start bit driven at load, then data LSB first and stop.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tx_busy  <= 1'b0;
         uart_tx  <= 1'b1;
         tx_shift <= '0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
      end else if (tx_start) begin
         tx_busy  <= 1'b1;
         uart_tx  <= 1'b0;
         tx_shift <= {1'b1, tx_byte};
         tx_cnt   <= '0;
         tx_bit   <= '0;
      end else if (tx_busy) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_busy <= 1'b0;
               uart_tx <= 1'b1;
            end else begin
               uart_tx  <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
               tx_bit   <= tx_bit + 1'b1;
            end
         end else tx_cnt <= tx_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_system_top.sv
// tb_system_top: randomized scoreboard bench for system_top (sequencer + UART echo).
module tb_system_top;

   localparam int unsigned HOLD = 40;
   localparam int unsigned CPB  = 8;

   logic sys_clk = 1'b0;
   logic sys_rst, init_calib_complete, host_done, uart_rx, uart_ctsn;
   logic uart_tx, uart_rtsn, core_rst, host_done_reg, calib_done_reg, uart_overrun;

   int checks = 0;
   int fails  = 0;
   logic [7:0] exp_q[$];
   logic frame_abort = 1'b0;

   // reference model state: the one-byte buffer and sticky overrun
   logic       m_full = 1'b0;
   logic [7:0] m_buf  = '0;
   logic       m_ovr  = 1'b0;

   system_top #(.RST_HOLD_CYCLES(HOLD), .CLKS_PER_BIT(CPB)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .init_calib_complete(init_calib_complete), .host_done(host_done),
      .uart_rx(uart_rx), .uart_ctsn(uart_ctsn), .uart_tx(uart_tx),
      .uart_rtsn(uart_rtsn), .core_rst(core_rst), .host_done_reg(host_done_reg),
      .calib_done_reg(calib_done_reg), .uart_overrun(uart_overrun)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_rst) frame_abort = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model of one received byte: direct echo if CTS allows, else buffer or overrun.
   task automatic model_rx(input logic [7:0] b, input logic stop);
      if (!stop) return;
      if (!uart_ctsn && !m_full) exp_q.push_back(b);
      else if (!m_full) begin m_full = 1'b1; m_buf = b; end
      else m_ovr = 1'b1;
   endtask

   task automatic model_cts_release();
      if (m_full) begin exp_q.push_back(m_buf); m_full = 1'b0; end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge sys_clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge sys_clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge sys_clk);
      model_rx(b, stop);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin @(negedge sys_clk); n++; end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (2 * CPB) @(negedge sys_clk);
   endtask

   task automatic wait_core_release(output int n);
      n = 0;
      while (core_rst && n < 20) begin @(negedge sys_clk); n++; end
   endtask

   task automatic expect_banner();
`ifdef BOOT_BANNER_EN
      exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      drain();
`endif
   endtask

   // Monitor: decode each frame on uart_tx and compare against the scoreboard.
   initial begin
      logic [7:0] d;
      logic st, sp;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst && uart_tx === 1'b0) begin
            frame_abort = 1'b0;
            repeat (CPB / 2 - 1) @(negedge sys_clk);
            st = uart_tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge sys_clk);
               d[i] = uart_tx;
            end
            repeat (CPB) @(negedge sys_clk);
            sp = uart_tx;
            if (!frame_abort) begin
               if (exp_q.size() == 0) begin
                  checks++; fails++;
                  $display("FAIL unexpected_tx_frame: got %02h, required no frame", d);
               end else begin
                  chk("tx_byte", 32'(d), 32'(exp_q.pop_front()));
                  chk("tx_start_stop", 32'({st, sp}), 32'h1);
               end
            end
         end
      end
   end

   initial begin
      int n;
      logic [7:0] b;
      logic s;
      sys_rst = 1'b1; init_calib_complete = 1'b0; host_done = 1'b0;
      uart_rx = 1'b1; uart_ctsn = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_rtsn", 32'(uart_rtsn), 32'd1);
      chk("rst_core_rst", 32'(core_rst), 32'd1);
      chk("rst_host_done_reg", 32'(host_done_reg), 32'd0);
      chk("rst_calib_done_reg", 32'(calib_done_reg), 32'd0);
      chk("rst_overrun", 32'(uart_overrun), 32'd0);

      // sequencing: calib early, host_done late
      sys_rst = 1'b0;
      repeat (10) @(negedge sys_clk);
      init_calib_complete = 1'b1;
      repeat (4) @(negedge sys_clk);
      chk("calib_synced", 32'(calib_done_reg), 32'd1);
      repeat (46) @(negedge sys_clk);
      chk("core_rst_before_host", 32'(core_rst), 32'd1);
      chk("rtsn_before_run", 32'(uart_rtsn), 32'd1);
      host_done = 1'b1;
      wait_core_release(n);
      chk("host_to_core_release_cycles", 32'(n), 32'd4);
      chk("host_done_reg_set", 32'(host_done_reg), 32'd1);
      expect_banner();

      // early host_done: sticky during HOLD, calib releases
      sys_rst = 1'b1; host_done = 1'b0; init_calib_complete = 1'b0;
      @(negedge sys_clk);
      chk("rst2_core_rst", 32'(core_rst), 32'd1);
      sys_rst = 1'b0;
      repeat (5) @(negedge sys_clk);
      host_done = 1'b1;
      repeat (5) @(negedge sys_clk);
      chk("early_host_done_reg", 32'(host_done_reg), 32'd1);
      chk("early_core_rst_held", 32'(core_rst), 32'd1);
      repeat (80) @(negedge sys_clk);
      chk("core_rst_before_calib", 32'(core_rst), 32'd1);
      init_calib_complete = 1'b1;
      wait_core_release(n);
      chk("calib_to_core_release_cycles", 32'(n), 32'd5);
      expect_banner();
      chk("rtsn_run_idle", 32'(uart_rtsn), 32'd0);

      // echo: fixed pattern then random bytes with random stop bits
      send_rx(8'hA5, 1'b1);
      drain();
      for (int unsigned i = 0; i < 8; i++) begin
         b = 8'($urandom);
         s = ($urandom_range(0, 3) != 0);
         send_rx(b, s);
         drain();
         chk("rtsn_after_echo", 32'(uart_rtsn), 32'd0);
         chk("overrun_echo", 32'(uart_overrun), 32'(m_ovr));
      end

      // short low glitch on rx must not start a byte
      uart_rx = 1'b0;
      repeat (2) @(negedge sys_clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge sys_clk);
      send_rx(8'h5A, 1'b1);
      drain();

      // framing error: no echo, no overrun
      send_rx(8'h12, 1'b0);
      drain();
      chk("framing_no_overrun", 32'(uart_overrun), 32'd0);

      // flow control: CTS blocks, second byte overruns, first is retained
      uart_ctsn = 1'b1;
      repeat (4) @(negedge sys_clk);
      send_rx(8'h3C, 1'b1);
      chk("rtsn_while_buffered", 32'(uart_rtsn), 32'd1);
      send_rx(8'h55, 1'b1);
      chk("overrun_set", 32'(uart_overrun), 32'(m_ovr));
      repeat (4 * CPB) @(negedge sys_clk);
      chk("tx_idle_while_cts_high", 32'(uart_tx), 32'd1);
      uart_ctsn = 1'b0;
      model_cts_release();
      drain();
      repeat (12 * CPB) @(negedge sys_clk);
      chk("rtsn_after_release", 32'(uart_rtsn), 32'd0);
      chk("overrun_sticky", 32'(uart_overrun), 32'd1);

      // reset mid-frame
      send_rx(8'hC3, 1'b1);
      n = 0;
      while (uart_tx && n < 100) begin @(negedge sys_clk); n++; end
      chk("tx_started_for_reset", 32'(uart_tx), 32'd0);
      repeat (3 * CPB) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      chk("midframe_rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("midframe_rst_core_rst", 32'(core_rst), 32'd1);
      chk("midframe_rst_rtsn", 32'(uart_rtsn), 32'd1);
      chk("midframe_rst_overrun", 32'(uart_overrun), 32'd0);
      chk("midframe_rst_host_reg", 32'(host_done_reg), 32'd0);
      exp_q.delete();
      m_full = 1'b0; m_ovr = 1'b0;
      repeat (12 * CPB) @(negedge sys_clk);
      chk("rst_hold_uart_tx", 32'(uart_tx), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
